spi_target: RTL and testbench

- SPI responder (slave) for the opposite end of the SPI link driven by the bus sequencer.
- Used as an on-chip loopback target for bring-up, and as a sequencer-testable peripheral model.
- Samples spi_sclk_i, spi_ncs_i and spi_mosi_i in the clk_i domain through synchronizers, and deserializes MOSI bytes to a valid-pulse output.
- Serializes bytes from a single-entry TX holding register onto MISO. SPI mode is set by parameters.

---
 rtl/spi_target.sv | 162 ++++++++++++++++
 tb/tb_spi_target.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI responder: synchronizes the master's SCLK/nCS/MOSI into clk_i, deserializes
// MOSI bytes and serializes a single-entry TX holding register onto MISO.
module spi_target #(
  parameter bit         SPI_CPOL    = 1'b0,
  parameter bit         SPI_CPHA    = 1'b0,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_MISO   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       spi_sclk_i,
  input  logic       spi_ncs_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_t,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_load_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic       frame_active_o,
  output logic       frame_end_o,
  output logic [7:0] byte_cnt_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, mosi_sync;
  logic                   sclk_d, ncs_d;
  logic                   sclk_s, ncs_s, mosi_s;

  state_t     state;
  logic [6:0] rx_shift;
  logic [2:0] bit_cnt;
  logic [7:0] tx_shift;
  logic [7:0] hold_reg;
  logic       hold_full;
  logic       load_pending;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge, ncs_fall, ncs_rise;
  logic in_frame, load_point;

  // The nCS chain resets to "asserted" so a chip select still held low when
  // reset is released never looks like a fresh falling edge.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sclk_sync <= {SYNC_STAGES{SPI_CPOL}};
      ncs_sync  <= '0;
      mosi_sync <= '0;
      sclk_d    <= SPI_CPOL;
      ncs_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi_ncs_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign lead_edge   = SPI_CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = SPI_CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = SPI_CPHA ? trail_edge : lead_edge;
  assign shift_edge  = SPI_CPHA ? lead_edge : trail_edge;
  assign ncs_fall    = ~ncs_s & ncs_d;
  assign ncs_rise    = ncs_s & ~ncs_d;

  // A deassertion in the same cycle as an SCLK edge wins over that edge.
  assign in_frame   = (state == ACTIVE) && !ncs_rise;
  assign load_point = SPI_CPHA ? (in_frame && shift_edge && bit_cnt == 3'd0)
                               : ((state == IDLE && ncs_fall) ||
                                  (in_frame && shift_edge && load_pending));

  assign spi_miso_o = spi_miso_t ? 1'b1 : tx_shift[7];
  assign tx_ready_o = ~hold_full;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state          <= IDLE;
      rx_shift       <= '0;
      bit_cnt        <= '0;
      tx_shift       <= '0;
      hold_reg       <= '0;
      hold_full      <= 1'b0;
      load_pending   <= 1'b0;
      spi_miso_t     <= 1'b1;
      rx_data_o      <= '0;
      rx_valid_o     <= 1'b0;
      tx_underrun_o  <= 1'b0;
      frame_active_o <= 1'b0;
      frame_end_o    <= 1'b0;
      byte_cnt_o     <= '0;
    end else begin
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      frame_end_o   <= 1'b0;

      if (load_point) begin
        if (hold_full) begin
          tx_shift  <= hold_reg;
          hold_full <= 1'b0;
        end else begin
          tx_shift      <= IDLE_MISO;
          tx_underrun_o <= 1'b1;
        end
      end else if (in_frame && shift_edge) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      // A load is only taken while empty, so it never collides with the drain above.
      if (tx_load_i && !hold_full) begin
        hold_reg  <= tx_data_i;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state          <= ACTIVE;
            frame_active_o <= 1'b1;
            byte_cnt_o     <= '0;
            bit_cnt        <= '0;
            rx_shift       <= '0;
            load_pending   <= 1'b0;
            spi_miso_t     <= 1'b0;
          end
        end
        ACTIVE: begin
          if (ncs_rise) begin
            state          <= IDLE;
            frame_active_o <= 1'b0;
            frame_end_o    <= 1'b1;
            spi_miso_t     <= 1'b1;
            bit_cnt        <= '0;
            load_pending   <= 1'b0;
          end else if (sample_edge) begin
            rx_shift <= {rx_shift[5:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_o    <= {rx_shift, mosi_s};
              rx_valid_o   <= 1'b1;
              load_pending <= 1'b1;
              if (byte_cnt_o != 8'hFF) byte_cnt_o <= byte_cnt_o + 8'd1;
            end
          end else if (shift_edge) begin
            load_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Testbench for spi_target: one instance per SPI mode, driven by a shared
// master model that selects one target at a time through its own chip select.
module tb_spi_target;

  logic       clk;
  logic       nrst;
  logic       phase;
  logic [3:0] sclk;
  logic [3:0] ncs;
  logic       mosi;
  logic [7:0] tx_data;
  logic [3:0] tx_load;

  logic [3:0] miso_w, miso_t_w, rx_valid_w, tx_ready_w, underrun_w, active_w, fend_w;
  logic [7:0] rx_data_w [4];
  logic [7:0] byte_cnt_w [4];

  int mode;
  int check_cnt;
  int pass_cnt;
  int valid_cnt, underrun_cnt, fend_cnt;
  int v0, u0, f0;
  logic [7:0] mi, mi0, mi1;

  // Mode k: CPOL = k[1], CPHA = k[0]; phase 0 is always the idle level.
  assign sclk = {4{phase}} ^ 4'b1100;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    spi_target #(
      .SPI_CPOL    (k >= 2),
      .SPI_CPHA    (k % 2 == 1),
      .SYNC_STAGES (2),
      .IDLE_MISO   (8'hFF)
    ) dut (
      .clk_i          (clk),
      .nrst_i         (nrst),
      .spi_sclk_i     (sclk[k]),
      .spi_ncs_i      (ncs[k]),
      .spi_mosi_i     (mosi),
      .spi_miso_o     (miso_w[k]),
      .spi_miso_t     (miso_t_w[k]),
      .rx_data_o      (rx_data_w[k]),
      .rx_valid_o     (rx_valid_w[k]),
      .tx_data_i      (tx_data),
      .tx_load_i      (tx_load[k]),
      .tx_ready_o     (tx_ready_w[k]),
      .tx_underrun_o  (underrun_w[k]),
      .frame_active_o (active_w[k]),
      .frame_end_o    (fend_w[k]),
      .byte_cnt_o     (byte_cnt_w[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid_w[mode]) valid_cnt++;
    if (underrun_w[mode]) underrun_cnt++;
    if (fend_w[mode]) fend_cnt++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] d);
    tx_data = d;
    tx_load[mode] = 1'b1;
    @(negedge clk);
    tx_load[mode] = 1'b0;
  endtask

  task automatic frame_start();
    ncs[mode] = 1'b0;
    wait_clks(6);
  endtask

  task automatic frame_stop();
    wait_clks(6);
    ncs[mode] = 1'b1;
    wait_clks(8);
  endtask

  // Master side of one byte (or its first nbits bits), MSB first.
  task automatic applyStimulus(input logic [7:0] mo, input int nbits, output logic [7:0] mi_o);
    mi_o = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (mode % 2 == 0) begin
        mosi = mo[i];
        wait_clks(6);
        mi_o[i] = miso_w[mode];
        phase = 1'b1;
        wait_clks(6);
        phase = 1'b0;
      end else begin
        phase = 1'b1;
        mosi = mo[i];
        wait_clks(6);
        mi_o[i] = miso_w[mode];
        phase = 1'b0;
        wait_clks(6);
      end
    end
    if (mode % 2 == 0) wait_clks(6);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_miso"},     8'(miso_w[0]),     8'd1);
    checkOutput({tag, "_miso_t"},   8'(miso_t_w[0]),   8'd1);
    checkOutput({tag, "_rx_data"},  rx_data_w[0],      8'h00);
    checkOutput({tag, "_rx_valid"}, 8'(rx_valid_w[0]), 8'd0);
    checkOutput({tag, "_ready"},    8'(tx_ready_w[0]), 8'd1);
    checkOutput({tag, "_underrun"}, 8'(underrun_w[0]), 8'd0);
    checkOutput({tag, "_active"},   8'(active_w[0]),   8'd0);
    checkOutput({tag, "_fend"},     8'(fend_w[0]),     8'd0);
    checkOutput({tag, "_byte_cnt"}, byte_cnt_w[0],     8'h00);
  endtask

  initial begin
    check_cnt = 0; pass_cnt = 0;
    valid_cnt = 0; underrun_cnt = 0; fend_cnt = 0;
    nrst = 1'b0; ncs = 4'hF; phase = 1'b0; mosi = 1'b0;
    tx_data = 8'h00; tx_load = 4'h0; mode = 0;
    wait_clks(3);
    check_reset_values("por");
    nrst = 1'b1;
    wait_clks(4);

    // Mode 0 single byte with preloaded TX
    mode = 0;
    load_tx(8'hA5);
    checkOutput("t1_ready_after_load", 8'(tx_ready_w[0]), 8'd0);
    v0 = valid_cnt; f0 = fend_cnt;
    frame_start();
    checkOutput("t1_active", 8'(active_w[0]), 8'd1);
    checkOutput("t1_miso_t", 8'(miso_t_w[0]), 8'd0);
    checkOutput("t1_ready_after_entry", 8'(tx_ready_w[0]), 8'd1);
    applyStimulus(8'h3C, 8, mi);
    checkOutput("t1_miso_byte", mi, 8'hA5);
    checkOutput("t1_rx_data", rx_data_w[0], 8'h3C);
    checkOutput("t1_valid_pulses", 8'(valid_cnt - v0), 8'd1);
    checkOutput("t1_byte_cnt", byte_cnt_w[0], 8'd1);
    frame_stop();
    checkOutput("t1_fend_pulses", 8'(fend_cnt - f0), 8'd1);
    checkOutput("t1_active_after", 8'(active_w[0]), 8'd0);
    checkOutput("t1_miso_t_after", 8'(miso_t_w[0]), 8'd1);

    // Modes 1..3, two-byte frames with the second TX byte loaded mid-frame
    for (int m = 1; m < 4; m++) begin
      mode = m;
      v0 = valid_cnt;
      load_tx(8'hC3);
      frame_start();
      fork
        applyStimulus(8'h81, 8, mi0);
        begin
          for (int i = 0; i < 200 && tx_ready_w[mode] !== 1'b1; i++) @(negedge clk);
          checkOutput($sformatf("t2_m%0d_ready_wait", m), 8'(tx_ready_w[mode]), 8'd1);
          load_tx(8'h18);
        end
      join
      checkOutput($sformatf("t2_m%0d_miso0", m), mi0, 8'hC3);
      checkOutput($sformatf("t2_m%0d_rx0", m), rx_data_w[mode], 8'h81);
      applyStimulus(8'h7E, 8, mi1);
      checkOutput($sformatf("t2_m%0d_miso1", m), mi1, 8'h18);
      checkOutput($sformatf("t2_m%0d_rx1", m), rx_data_w[mode], 8'h7E);
      checkOutput($sformatf("t2_m%0d_byte_cnt", m), byte_cnt_w[mode], 8'd2);
      checkOutput($sformatf("t2_m%0d_valid_pulses", m), 8'(valid_cnt - v0), 8'd2);
      frame_stop();
    end

    // Mode 1, no TX load: one underrun per byte
    mode = 1;
    u0 = underrun_cnt;
    frame_start();
    applyStimulus(8'h55, 8, mi);
    checkOutput("t3_miso0", mi, 8'hFF);
    applyStimulus(8'hAA, 8, mi);
    checkOutput("t3_miso1", mi, 8'hFF);
    applyStimulus(8'h00, 8, mi);
    checkOutput("t3_miso2", mi, 8'hFF);
    checkOutput("t3_byte_cnt", byte_cnt_w[1], 8'd3);
    frame_stop();
    checkOutput("t3_underruns", 8'(underrun_cnt - u0), 8'd3);

    // Mode 0, partial byte then a full frame
    mode = 0;
    v0 = valid_cnt; f0 = fend_cnt;
    frame_start();
    applyStimulus(8'hF0, 5, mi);
    frame_stop();
    checkOutput("t4_partial_valid", 8'(valid_cnt - v0), 8'd0);
    checkOutput("t4_partial_fend", 8'(fend_cnt - f0), 8'd1);
    frame_start();
    applyStimulus(8'h0F, 8, mi);
    checkOutput("t4_rx_data", rx_data_w[0], 8'h0F);
    checkOutput("t4_valid", 8'(valid_cnt - v0), 8'd1);
    frame_stop();

    // Second load while full is dropped
    load_tx(8'h11);
    load_tx(8'h22);
    checkOutput("t5_ready", 8'(tx_ready_w[0]), 8'd0);
    frame_start();
    applyStimulus(8'h00, 8, mi);
    checkOutput("t5_miso0", mi, 8'h11);
    applyStimulus(8'h00, 8, mi);
    checkOutput("t5_miso1", mi, 8'hFF);
    frame_stop();

    // Reset in the middle of a byte with nCS still low
    load_tx(8'h5A);
    frame_start();
    applyStimulus(8'hA5, 4, mi);
    nrst = 1'b0;
    wait_clks(2);
    check_reset_values("rst_mid");
    nrst = 1'b1;
    wait_clks(4);
    v0 = valid_cnt; f0 = fend_cnt;
    applyStimulus(8'hFF, 8, mi);
    checkOutput("t6_active_ignored", 8'(active_w[0]), 8'd0);
    checkOutput("t6_miso_t_ignored", 8'(miso_t_w[0]), 8'd1);
    checkOutput("t6_valid_ignored", 8'(valid_cnt - v0), 8'd0);
    ncs[0] = 1'b1;
    wait_clks(8);
    checkOutput("t6_fend_ignored", 8'(fend_cnt - f0), 8'd0);
    load_tx(8'h96);
    frame_start();
    applyStimulus(8'hC9, 8, mi);
    checkOutput("t6_miso", mi, 8'h96);
    checkOutput("t6_rx_data", rx_data_w[0], 8'hC9);
    checkOutput("t6_byte_cnt", byte_cnt_w[0], 8'd1);
    frame_stop();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
